// File: rtl/lm32_mul_pkg.sv
// Shared mode encodings and limb sizing for the pipelined LM32 multiplier.
package lm32_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MULH_SS = 2'b01,
    MULH_SU = 2'b10,
    MULH_UU = 2'b11
  } mul_mode_e;

  // Number of LIMB-bit slices covering a WIDTH+1 bit extended operand.
  function automatic int limb_count(input int width, input int limb);
    return (width + limb) / limb;
  endfunction

endpackage

// File: rtl/lm32_mul_limb.sv
// One registered LIMB x LIMB unsigned partial product; holds its value while en is low.
module lm32_mul_limb #(
  parameter int LIMB = 17
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en,
  input  logic [LIMB-1:0]   a,
  input  logic [LIMB-1:0]   b,
  output logic [2*LIMB-1:0] p
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p <= '0;
    end else if (en) begin
      p <= (2*LIMB)'(a) * (2*LIMB)'(b);
    end
  end

endmodule

// File: rtl/lm32_mul_pipe.sv
// Three-stage pipelined multiplier (A: operands, B: limb products, C: summed product).
// Result two edges after capture; stall_x bubbles stage A, stall_m freezes A and B.
module lm32_mul_pipe
  import lm32_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LIMB  = 17
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_x,
  input  logic             stall_m,
  input  logic             kill_x,
  input  logic             valid_x,
  input  logic [1:0]       mode_x,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int N  = limb_count(WIDTH, LIMB);
  localparam int EW = N * LIMB;

  mul_mode_e                  mode_a, mode_b, mode_c;
  logic                       valid_a, valid_b, valid_c;
  logic [WIDTH-1:0]           op0_a, op1_a;
  logic                       sgn0_a, sgn1_a;
  logic [EW-1:0]              ext0_a, ext1_a;
  logic [WIDTH+1:0]           corr_a, corr_b;
  logic [N*N-1:0][2*LIMB-1:0] pp_b;
  logic [2*WIDTH-1:0]         sum_b, prod_c;
  logic                       adv_b;

  assign adv_b = ~stall_m;

  // Stage A: capture on an unstalled X, bubble on stall_x alone, freeze on stall_m.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_a <= 1'b0;
      mode_a  <= MUL_LO;
      op0_a   <= '0;
      op1_a   <= '0;
    end else if (!stall_m) begin
      if (stall_x) begin
        valid_a <= 1'b0;
      end else begin
        valid_a <= valid_x & ~kill_x;
        mode_a  <= mul_mode_e'(mode_x);
        op0_a   <= operand_0;
        op1_a   <= operand_1;
      end
    end
  end

  // Limbs are unsigned, so a signed operand's top bit (weight -2^WIDTH) is fed in as
  // +2^WIDTH and the excess 2^(WIDTH+1) * other_operand is subtracted back in stage C.
  always_comb begin
    sgn0_a = (mode_a == MULH_SS || mode_a == MULH_SU) && op0_a[WIDTH-1];
    sgn1_a = (mode_a == MULH_SS) && op1_a[WIDTH-1];
    ext0_a = '0;
    ext0_a[WIDTH:0] = {sgn0_a, op0_a};
    ext1_a = '0;
    ext1_a[WIDTH:0] = {sgn1_a, op1_a};
    corr_a = (sgn0_a ? {1'b0, sgn1_a, op1_a} : '0)
           + (sgn1_a ? {1'b0, sgn0_a, op0_a} : '0);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      lm32_mul_limb #(.LIMB(LIMB)) u_limb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (adv_b),
        .a       (ext0_a[gi*LIMB +: LIMB]),
        .b       (ext1_a[gj*LIMB +: LIMB]),
        .p       (pp_b[gi*N+gj])
      );
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_b <= 1'b0;
      mode_b  <= MUL_LO;
      corr_b  <= '0;
    end else if (adv_b) begin
      valid_b <= valid_a;
      mode_b  <= mode_a;
      corr_b  <= corr_a;
    end
  end

  // Only the low 2*WIDTH bits matter, so every term is truncated before shifting.
  always_comb begin
    sum_b = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_b = sum_b + ((2*WIDTH)'(pp_b[i*N+j]) << ((i + j) * LIMB));
      end
    end
    sum_b = sum_b - ((2*WIDTH)'(corr_b) << (WIDTH + 1));
  end

  // Stage C reloads every edge; a frozen stage B keeps it stable during stall_m.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_c <= 1'b0;
      mode_c  <= MUL_LO;
      prod_c  <= '0;
    end else begin
      valid_c <= valid_b;
      mode_c  <= mode_b;
      prod_c  <= sum_b;
    end
  end

  assign result       = (mode_c == MUL_LO) ? prod_c[WIDTH-1:0] : prod_c[2*WIDTH-1:WIDTH];
  assign result_valid = valid_c;

endmodule

// File: tb/tb_lm32_mul_pipe.sv
// Self-checking bench: 32-bit/LIMB17 and 24-bit/LIMB8 instances share pipeline control.
module tb_lm32_mul_pipe;

  localparam logic [1:0] M_LO = 2'b00, M_SS = 2'b01, M_SU = 2'b10, M_UU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_x, stall_m, kill_x, valid_x;
  logic [1:0]  mode_x;
  logic [31:0] op0_32, op1_32, res32;
  logic [23:0] op0_24, op1_24, res24;
  logic        vld32, vld24;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q32[$];
  logic [63:0] q24[$];
  bit          adv_prev = 1'b1;
  bit          slot_new;

  always #5 clk_i = ~clk_i;

  lm32_mul_pipe #(.WIDTH(32), .LIMB(17)) u_dut32 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_x(stall_x), .stall_m(stall_m),
    .kill_x(kill_x), .valid_x(valid_x), .mode_x(mode_x),
    .operand_0(op0_32), .operand_1(op1_32), .result(res32), .result_valid(vld32)
  );

  lm32_mul_pipe #(.WIDTH(24), .LIMB(8)) u_dut24 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_x(stall_x), .stall_m(stall_m),
    .kill_x(kill_x), .valid_x(valid_x), .mode_x(mode_x),
    .operand_0(op0_24), .operand_1(op1_24), .result(res24), .result_valid(vld24)
  );

  // Reference: interpret operands as integers per mode, multiply, pick a half.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] md,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed({66'd0, a & mask});
    sb = $signed({66'd0, b & mask});
    if ((md == M_SS || md == M_SU) && a[w-1]) sa = sa - (130'sd1 <<< w);
    if (md == M_SS && b[w-1]) sb = sb - (130'sd1 <<< w);
    p = sa * sb;
    if (md != M_LO) p = p >>> w;
    return p[63:0] & mask;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: return m;
      1: return 64'd1 << (w - 1);
      2: return 64'd0;
      3: return m >> 1;
      default: return {$urandom(), $urandom()} & m;
    endcase
  endfunction

  // Drives one cycle and records what the model expects; outputs sampled at the following negedge.
  task automatic drive(input logic vx, input logic kx, input logic sx, input logic sm,
                       input logic [1:0] md, input logic [31:0] a32, input logic [31:0] b32,
                       input logic [23:0] a24, input logic [23:0] b24);
    valid_x = vx; kill_x = kx; stall_m = sm; stall_x = sx | sm; mode_x = md;
    op0_32 = a32; op1_32 = b32; op0_24 = a24; op1_24 = b24;
    if (!(sx | sm) && vx && !kx) begin
      q32.push_back(ref_mul(32, md, {32'd0, a32}, {32'd0, b32}));
      q24.push_back(ref_mul(24, md, {40'd0, a24}, {40'd0, b24}));
    end
    slot_new = adv_prev;
    adv_prev = !sm;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, M_LO, 32'd0, 32'd0, 24'd0, 24'd0);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    valid_x = 0; kill_x = 0; stall_x = 0; stall_m = 0; mode_x = M_LO;
    op0_32 = '1; op1_32 = '1; op0_24 = '1; op1_24 = '1;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if (res32 !== 32'd0 || vld32 !== 1'b0 || res24 !== 24'd0 || vld24 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: res32=%h vld32=%b res24=%h vld24=%b, required all 0",
               res32, vld32, res24, vld24);
    end
    rst_n_i = 1'b1;
    idle();
    n_tests++;
    if (vld32 !== 1'b0 || res32 !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: res32=%h vld32=%b, required 0/0", res32, vld32);
    end
    q32.delete(); q24.delete();
  endtask

  task automatic test_latency();
    logic exp_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 1'b0, M_LO, 32'h0000_FFFF, 32'h0001_0001, 24'd3, 24'd5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle();
      n_tests++;
      if (vld32 !== exp_v[k] || (exp_v[k] && res32 !== 32'hFFFF_FFFF)) begin
        n_fail++;
        $display("FAIL latency_edge%0d: vld=%b res=%h, required vld=%b res=ffffffff",
                 k, vld32, res32, exp_v[k]);
      end
    end
    q32.delete(); q24.delete();
  endtask

  task automatic test_vectors();
    logic [1:0]  vm[7] = '{M_LO, M_SS, M_LO, M_UU, M_SS, M_SU, M_LO};
    logic [31:0] va[7] = '{32'h0000_FFFF, 32'h8000_0000, 32'h8000_0000, '1, '1, '1, '1};
    logic [31:0] vb[7] = '{32'h0001_0001, 32'h8000_0000, 32'h8000_0000, '1, '1, '1, '1};
    logic [31:0] ve[7] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE,
                           32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int k = 0; k < 9; k++) begin
      if (k < 7) drive(1'b1, 1'b0, 1'b0, 1'b0, vm[k], va[k], vb[k], 24'd0, 24'd0);
      else idle();
      if (k >= 2) begin
        n_tests++;
        if (vld32 !== 1'b1 || res32 !== ve[k-2]) begin
          n_fail++;
          $display("FAIL vector%0d: vld=%b res=%h, required vld=1 res=%h",
                   k - 2, vld32, res32, ve[k-2]);
        end
      end
    end
    q32.delete(); q24.delete();
  endtask

  task automatic test_kill();
    logic [31:0] a[3], b[3];
    logic [1:0]  m[3];
    logic [31:0] e;
    for (int k = 0; k < 3; k++) begin
      a[k] = pick(32); b[k] = pick(32); m[k] = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drive(1'b1, k == 1, 1'b0, 1'b0, m[k], a[k], b[k], 24'd0, 24'd0);
      else idle();
      if (k >= 2 && k <= 4) begin
        e = ref_mul(32, m[k-2], {32'd0, a[k-2]}, {32'd0, b[k-2]});
        n_tests++;
        if (k == 3 ? (vld32 !== 1'b0) : (vld32 !== 1'b1 || res32 !== e)) begin
          n_fail++;
          $display("FAIL kill_slot%0d: vld=%b res=%h, required vld=%b res=%h",
                   k - 2, vld32, res32, k != 3, e);
        end
      end
    end
    q32.delete(); q24.delete();
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, M_LO, 32'h1234 + k, 32'h5678, 24'h12, 24'h34);
    n_tests++;
    if (vld32 !== 1'b1 || res32 !== 32'h1234 * 32'h5678) begin
      n_fail++;
      $display("FAIL pre_reset_op: vld=%b res=%h, required vld=1 res=%h",
               vld32, res32, 32'h1234 * 32'h5678);
    end
    valid_x = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    n_tests++;
    if (res32 !== 32'd0 || vld32 !== 1'b0 || res24 !== 24'd0 || vld24 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: res32=%h vld32=%b res24=%h vld24=%b, required all 0",
               res32, vld32, res24, vld24);
    end
    q32.delete(); q24.delete();
    adv_prev = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      n_tests++;
      if (vld32 !== 1'b0 || vld24 !== 1'b0) begin
        n_fail++;
        $display("FAIL discarded_op%0d: vld32=%b vld24=%b, required 0", k, vld32, vld24);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, M_UU, 32'hFFFF_FFFF, 32'h0000_0002, 24'hFFFFFF, 24'h2);
    idle();
    n_tests++;
    if (vld32 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_early: vld=%b, required 0", vld32);
    end
    idle();
    n_tests++;
    if (vld32 !== 1'b1 || res32 !== 32'h1 || vld24 !== 1'b1 || res24 !== 24'h1) begin
      n_fail++;
      $display("FAIL post_reset_op: vld32=%b res32=%h vld24=%b res24=%h, required 1/1/1/1",
               vld32, res32, vld24, res24);
    end
    idle(); idle();
    q32.delete(); q24.delete();
  endtask

  // Scoreboarded traffic: in-order results, held stable whenever stage B did not advance.
  task automatic test_back_to_back(input int ncyc, input int stall_at, input bit rnd);
    logic [31:0] last32;
    logic [23:0] last24;
    logic        lv32, lv24, vx, kx, sx, sm;
    logic [63:0] e;
    last32 = res32; lv32 = vld32; last24 = res24; lv24 = vld24;
    for (int c = 0; c < ncyc + 8; c++) begin
      if (rnd) begin
        vx = (c < ncyc) && ($urandom_range(0, 9) < 7);
        kx = ($urandom_range(0, 9) == 0);
        sm = (c < ncyc) && ($urandom_range(0, 9) == 0);
        sx = ($urandom_range(0, 9) == 0);
      end else begin
        vx = (c < ncyc);
        kx = 1'b0;
        sm = (c >= stall_at) && (c < stall_at + 3);
        sx = 1'b0;
      end
      drive(vx, kx, sx, sm, 2'($urandom_range(0, 3)), 32'(pick(32)), 32'(pick(32)),
            24'(pick(24)), 24'(pick(24)));
      if (slot_new) begin
        if (vld32) begin
          e = (q32.size() > 0) ? q32.pop_front() : 64'hDEAD;
          n_tests++;
          if (res32 !== e[31:0]) begin
            n_fail++;
            $display("FAIL order32 cyc%0d: res=%h, required %h", c, res32, e[31:0]);
          end
        end
        if (vld24) begin
          e = (q24.size() > 0) ? q24.pop_front() : 64'hDEAD;
          n_tests++;
          if (res24 !== e[23:0]) begin
            n_fail++;
            $display("FAIL order24 cyc%0d: res=%h, required %h", c, res24, e[23:0]);
          end
        end
      end else begin
        n_tests++;
        if (res32 !== last32 || vld32 !== lv32 || res24 !== last24 || vld24 !== lv24) begin
          n_fail++;
          $display("FAIL stall_hold cyc%0d: res32=%h/%b res24=%h/%b, required %h/%b %h/%b",
                   c, res32, vld32, res24, vld24, last32, lv32, last24, lv24);
        end
      end
      last32 = res32; lv32 = vld32; last24 = res24; lv24 = vld24;
    end
    n_tests++;
    if (q32.size() != 0 || q24.size() != 0) begin
      n_fail++;
      $display("FAIL lost_results: pending32=%0d pending24=%0d, required 0 0",
               q32.size(), q24.size());
    end
    q32.delete(); q24.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_kill();
    test_back_to_back(12, 5, 1'b0);
    test_reset_midflight();
    test_back_to_back(600, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lm32_mul_pipe.md
LM32_MUL_PIPE -- requirements
Module: lm32_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width, 8..64.
REQ-002 SHALL have parameter LIMB, default 17: unsigned limb width fed to each DSP multiplier, 8..24.
REQ-003 SHALL have port clk_i, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port stall_x, input, 1: X stage stalled; stage A holds.
REQ-006 SHALL have port stall_m, input, 1: M stage stalled; stage B holds; stall_m=1 implies stall_x=1 (input constraint).
REQ-007 SHALL have port kill_x, input, 1: instruction leaving X is squashed.
REQ-008 SHALL have port valid_x, input, 1: multiply issued in X this cycle.
REQ-009 SHALL have port mode_x, input, 2: 00 MUL (low), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high).
REQ-010 SHALL have ports operand_0 and operand_1, input, WIDTH: multiplicand and multiplier.
REQ-011 SHALL have port result, output, WIDTH: selected product half.
REQ-012 SHALL have port result_valid, output, 1: result belongs to a live multiply.

Function
REQ-013 SHALL capture operands, mode and valid into stage A on each edge with stall_x=0; valid_a <= valid_x & ~kill_x.
REQ-014 SHALL clear valid_a when stall_x=1 and stall_m=0 (bubble), and hold all stage A state when stall_m=1.
REQ-015 SHALL sign- or zero-extend operands to WIDTH+1 bits per mode (operand_0 signed for 01,10; operand_1 signed for 01 only; MUL result mode-independent).
REQ-016 SHALL split each extended operand into N=ceil((WIDTH+1)/LIMB) limbs and register all N*N limb products in stage B on edges with stall_m=0; valid_b <= valid_a.
REQ-017 SHALL compute the 2*WIDTH-bit product as the shifted sum of stage B limb products, and register it in stage C on every edge unconditionally.
REQ-018 SHALL drive result from stage C: bits [WIDTH-1:0] for mode 00, bits [2*WIDTH-1:WIDTH] otherwise; result_valid = valid_c.
REQ-019 SHALL present the result two edges after the stage A capture edge with no stalls (result visible in the cycle after the stage C edge); each stall_m cycle adds one.
REQ-020 SHALL keep result and result_valid stable while stall_m=1 after stage C has loaded.
REQ-021 SHALL never let kill_x alter stages B or C; a killed op SHALL produce result_valid=0 but may update result data.
REQ-022 SHALL be fully pipelined: one new op accepted per unstalled cycle, no internal busy state.

Reset
REQ-023 SHALL on rst_n_i=0 asynchronously clear valid_a, valid_b, valid_c, all data registers, result (0) and result_valid (0).
REQ-024 SHALL discard any in-flight op when reset asserts mid-operation; first accepted op after deassertion follows REQ-019.

Structure
REQ-025 SHALL place mode encodings (MUL_LO, MULH_SS, MULH_SU, MULH_UU) and limb-count function in package lm32_mul_pkg.
REQ-026 SHALL instantiate sub-module lm32_mul_limb (one registered LIMB x LIMB unsigned product with enable and async reset) N*N times via generate.
REQ-027 SHALL contain no vendor primitives; DSP inference left to synthesis.

Verification
REQ-028 WIDTH=32, MUL 0x0000FFFF*0x00010001, no stalls -> result 0xFFFFFFFF, result_valid=1, two edges after capture.
REQ-029 MULH 0x80000000*0x80000000 -> 0x40000000; MUL same operands -> 0x00000000.
REQ-030 0xFFFFFFFF*0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-031 Back-to-back ops with stall_m=1 for 3 cycles mid-stream -> results in issue order, each held stable during stall, none duplicated or lost.
REQ-032 kill_x=1 on capture edge -> result_valid stays 0 for that slot; neighbouring ops unaffected.
REQ-033 rst_n_i pulsed low with two ops in flight -> result=0, result_valid=0 immediately; random signed/unsigned sweep at WIDTH=24, LIMB=8 matches reference model.
